// File: rtl/serial_paralelo_pkg.sv
// Shared definitions for the serial-to-parallel receiver and its
// parallel-to-serial transmit stage: alignment symbol, lock depth and
// receiver state encoding.
package serial_paralelo_pkg;

   // Idle / alignment symbol sent by the transmitter whenever it has no data
   localparam logic [7:0] COMMA = 8'hBC;

   // Consecutive byte-aligned COMMA symbols needed before data is accepted
   localparam int unsigned LOCK_COUNT = 4;

   // Receiver alignment states
   typedef enum logic [1:0] {
      HUNT   = 2'b00,
      COUNT  = 2'b01,
      ACTIVE = 2'b10
   } state_t;

endpackage : serial_paralelo_pkg

// File: rtl/serial_paralelo_tx.sv
// Parallel-to-serial transmit stage. A byte is taken every 8 bit times and
// shifted out MSB first. When no valid byte is offered, the COMMA symbol is
// sent instead, so the receiver always sees a byte-aligned stream.
// ready is high during the bit time whose closing edge loads the next byte.
module serial_paralelo_tx
   import serial_paralelo_pkg::*;
#(
   parameter logic [7:0] COMMA = serial_paralelo_pkg::COMMA
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       data_out,
   output logic       ready
);

   logic [7:0] sreg;
   logic [2:0] cnt;

   // The serial bit is the MSB of the output shift register
   assign data_out = sreg[7];

   // Bit counter, byte load and shift; a COMMA is loaded while idle
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         sreg  <= COMMA;
         cnt   <= 3'd0;
         ready <= 1'b0;
      end else begin
         cnt   <= cnt + 3'd1;
         ready <= (cnt == 3'd6);
         if (cnt == 3'd7) begin
            sreg <= valid_in ? data_in : COMMA;
         end else begin
            sreg <= {sreg[6:0], 1'b0};
         end
      end
   end

endmodule : serial_paralelo_tx

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver with COMMA-based byte alignment.
// HUNT looks for the COMMA at any bit phase, COUNT confirms LOCK_COUNT
// COMMAs on consecutive byte boundaries, and ACTIVE delivers every
// non-COMMA byte on data_out with a one-cycle valid_out strobe. Lock is
// only released by reset.
module serial_paralelo
   import serial_paralelo_pkg::*;
#(
   parameter logic [7:0]  COMMA      = serial_paralelo_pkg::COMMA,
   parameter int unsigned LOCK_COUNT = serial_paralelo_pkg::LOCK_COUNT
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 1);

   // Only the seven most recent bits are kept: the eighth bit of the shift
   // window would never be read, because the candidate byte already takes
   // the incoming bit straight from data_in.
   logic [6:0]       sr;
   logic [7:0]       cand;
   logic [2:0]       bit_cnt;
   logic [CNT_W-1:0] comma_cnt;
   state_t           state;
   state_t           state_next;
   logic             boundary;
   logic             is_comma;
   logic             lock_hit;

   // Candidate byte and the qualifiers derived from it and the counters
   always_comb begin
      cand     = {sr, data_in};
      is_comma = (cand == COMMA);
      boundary = (bit_cnt == 3'd7);
      lock_hit = (comma_cnt == CNT_W'(LOCK_COUNT - 1));
   end

   // Serial shift register, MSB arrives first
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         sr <= 7'd0;
      end else begin
         sr <= cand[6:0];
      end
   end

   // Bit phase counter: held at zero while hunting, free-running once a
   // COMMA has fixed the byte phase
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         bit_cnt <= 3'd0;
      end else begin
         case (state)
            HUNT:    bit_cnt <= 3'd0;
            COUNT:   bit_cnt <= bit_cnt + 3'd1;
            ACTIVE:  bit_cnt <= bit_cnt + 3'd1;
            default: bit_cnt <= 3'd0;
         endcase
      end
   end

   // Count of COMMAs seen on consecutive byte boundaries
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         comma_cnt <= '0;
      end else begin
         case (state)
            HUNT: begin
               if (is_comma) begin
                  comma_cnt <= CNT_W'(1);
               end else begin
                  comma_cnt <= '0;
               end
            end
            COUNT: begin
               if (boundary) begin
                  if (is_comma) begin
                     comma_cnt <= comma_cnt + CNT_W'(1);
                  end else begin
                     comma_cnt <= '0;
                  end
               end else begin
                  comma_cnt <= comma_cnt;
               end
            end
            ACTIVE:  comma_cnt <= comma_cnt;
            default: comma_cnt <= '0;
         endcase
      end
   end

   // Alignment state register
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state <= HUNT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a broken COMMA run sends the receiver back to HUNT
   always_comb begin
      state_next = state;
      case (state)
         HUNT: begin
            if (is_comma) begin
               state_next = COUNT;
            end else begin
               state_next = HUNT;
            end
         end
         COUNT: begin
            if (boundary) begin
               if (!is_comma) begin
                  state_next = HUNT;
               end else if (lock_hit) begin
                  state_next = ACTIVE;
               end else begin
                  state_next = COUNT;
               end
            end else begin
               state_next = COUNT;
            end
         end
         ACTIVE:  state_next = ACTIVE;
         default: state_next = HUNT;
      endcase
   end

   // Registered outputs: data byte capture, valid strobe and lock flag
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         data_out  <= 8'h00;
         valid_out <= 1'b0;
         active    <= 1'b0;
      end else begin
         active <= (state_next == ACTIVE);
         if ((state == ACTIVE) && boundary && !is_comma) begin
            data_out  <= cand;
            valid_out <= 1'b1;
         end else begin
            data_out  <= data_out;
            valid_out <= 1'b0;
         end
      end
   end

endmodule : serial_paralelo
